instruction_fetch: RTL and testbench

Fetch stage of the RV32I core. Holds the program counter, issues word requests to instruction memory over a request/grant + in-order response interface, and buffers up to two returned words. Presents them to the instruction decoder as `instruction_code` qualified by `en`, with a ready/valid backpressure handshake. Branch/jump redirects from execute flush all in-flight and buffered instructions.

---
 rtl/instruction_fetch_if.sv | 26 ++
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect and
// the ready/valid handoff to the decoder.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        en;
  logic [31:0] instruction_code;
  logic [31:0] inst_pc;
  logic        misaligned;

  modport master (
    output imem_req, imem_addr, en, instruction_code, inst_pc, misaligned,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, en, instruction_code, inst_pc, misaligned,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: PC, credit-limited imem requests, 2-entry instruction buffer toward
// the decoder, and redirect flush with kill counting of in-flight returns.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  kill_q, kill_d;
  logic [1:0]  count_q, count_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fifo_word_q [2];
  logic [31:0] fifo_word_d [2];
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] ifq_pc_q [2];
  logic [31:0] ifq_pc_d [2];

  logic       en;
  logic       pop;
  logic       req;
  logic       grant;
  logic       rsp;
  logic       live_rsp;
  logic [2:0] credit;
  logic       ifq_idx;
  logic       push_idx;

  always_comb begin
    en       = (count_q != 2'd0);
    pop      = en && bus.dec_ready;
    // Slots already claimed by in-flight requests and buffered words, net of this pop.
    credit   = {1'b0, outst_q} + {1'b0, count_q} - {2'b00, pop};
    req      = !bus.redirect && !misaligned_q && (credit < 3'd2);
    grant    = req && bus.imem_gnt;
    rsp      = bus.imem_rvalid && (outst_q != 2'd0);
    live_rsp = rsp && (kill_q == 2'd0);
    // Granting implies outst <= 1, so the new entry lands at outst - rsp.
    ifq_idx  = (outst_q == 2'd1) && !rsp;
    push_idx = ((count_q - {1'b0, pop}) == 2'd1);
  end

  always_comb begin
    pc_d         = pc_q;
    kill_d       = kill_q;
    misaligned_d = misaligned_q;
    fifo_word_d  = fifo_word_q;
    fifo_pc_d    = fifo_pc_q;
    ifq_pc_d     = ifq_pc_q;

    if (grant) pc_d = pc_q + 32'd4;
    outst_d = outst_q + {1'b0, grant} - {1'b0, rsp};

    if (rsp) ifq_pc_d[0] = ifq_pc_q[1];
    if (grant) ifq_pc_d[ifq_idx] = pc_q;

    if (rsp && (kill_q != 2'd0)) kill_d = kill_q - 2'd1;

    if (pop) begin
      fifo_word_d[0] = fifo_word_q[1];
      fifo_pc_d[0]   = fifo_pc_q[1];
    end
    if (live_rsp) begin
      fifo_word_d[push_idx] = bus.imem_rdata;
      fifo_pc_d[push_idx]   = ifq_pc_q[0];
    end
    count_d = count_q + {1'b0, live_rsp} - {1'b0, pop};

    // Redirect wins: everything still in flight after this cycle must be discarded.
    if (bus.redirect) begin
      count_d      = 2'd0;
      kill_d       = outst_q - {1'b0, rsp};
      pc_d         = {bus.redirect_pc[31:2], 2'b00};
      misaligned_d = (bus.redirect_pc[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      outst_q      <= 2'd0;
      kill_q       <= 2'd0;
      count_q      <= 2'd0;
      misaligned_q <= 1'b0;
      fifo_word_q  <= '{default: 32'h0};
      fifo_pc_q    <= '{default: 32'h0};
      ifq_pc_q     <= '{default: 32'h0};
    end else begin
      pc_q         <= pc_d;
      outst_q      <= outst_d;
      kill_q       <= kill_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
      fifo_word_q  <= fifo_word_d;
      fifo_pc_q    <= fifo_pc_d;
      ifq_pc_q     <= ifq_pc_d;
    end
  end

  always_comb begin
    bus.imem_req         = req;
    bus.imem_addr        = pc_q;
    bus.en               = en;
    bus.instruction_code = en ? fifo_word_q[0] : 32'h0;
    bus.inst_pc          = en ? fifo_pc_q[0] : 32'h0;
    bus.misaligned       = misaligned_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural memory with variable latency, a
// pop monitor, and an expected-PC scoreboard compared in order against observed pops.
module tb_instruction_fetch;
  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic clk;
  logic rst_n;
  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(ResetPc)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: responses in grant order, 'lat' cycles after grant.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];
  pend_t pnew;
  int    kcyc = 0;
  int    lat = 1;
  int    stray_cnt = 0;
  int    stray_seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end else begin
      kcyc++;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      if (pend.size() != 0 && pend[0].due <= kcyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memword(pend[0].addr);
        void'(pend.pop_front());
      end else if (stray_cnt != stray_seen) begin
        stray_seen      = stray_cnt;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
      end
      if (bus.imem_req && bus.imem_gnt) begin
        pnew.addr = bus.imem_addr;
        pnew.due  = kcyc + lat;
        pend.push_back(pnew);
      end
    end
  end

  // Pop monitor: records every instruction the decoder actually accepts.
  logic [31:0] obs_pc   [1024];
  logic [31:0] obs_word [1024];
  int          obs_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && bus.en && bus.dec_ready && !bus.redirect && obs_cnt < 1024) begin
      obs_pc[obs_cnt]   = bus.inst_pc;
      obs_word[obs_cnt] = bus.instruction_code;
      obs_cnt++;
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  int          rd = 0;
  int          base;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  task automatic drain(input string tag);
    logic [31:0] e;
    while (rd < obs_cnt) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_pc"}, obs_pc[rd], e);
      check({tag, "_word"}, obs_word[rd], memword(e));
      rd++;
    end
  endtask

  task automatic wait_en(input string tag);
    int k;
    k = 0;
    while (!bus.en && k < 20) begin
      tick(1);
      k++;
    end
    check1({tag, "_en_seen"}, bus.en, 1'b1);
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic [31:0] stream);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    #1;
    check1("req_low_in_redirect", bus.imem_req, 1'b0);
    drain("pre_redirect");
    set_stream(stream);
    tick(1);
    bus.redirect = 1'b0;
    #1;
  endtask

  initial begin
    int k;
    logic [31:0] head;
    rst_n           = 1'b0;
    bus.imem_gnt    = 1'b1;
    bus.dec_ready   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    set_stream(ResetPc);
    tick(3);
    check1("rst_en", bus.en, 1'b0);
    check("rst_code", bus.instruction_code, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check1("rst_misaligned", bus.misaligned, 1'b0);
    check("rst_addr", bus.imem_addr, ResetPc);

    // Streaming with a 1-cycle memory.
    rst_n = 1'b1;
    #1;
    check1("req_after_reset", bus.imem_req, 1'b1);
    check("addr_after_reset", bus.imem_addr, ResetPc);
    base = obs_cnt;
    tick(1);
    check1("en_one_after_grant", bus.en, 1'b0);
    tick(1);
    check1("en_two_after_grant", bus.en, 1'b1);
    check("first_inst_pc", bus.inst_pc, ResetPc);
    tick(18);
    check("no_bubbles", 32'(obs_cnt - base), 32'd18);
    drain("stream");

    // Decoder stall: buffer fills, requests stop, head stays put.
    bus.dec_ready = 1'b0;
    head = exp_q[0];
    base = obs_cnt;
    tick(1);
    check("stall_code_c1", bus.instruction_code, memword(head));
    check1("stall_req_c1", bus.imem_req, 1'b0);
    tick(3);
    check("stall_code_c4", bus.instruction_code, memword(head));
    check("stall_pc_c4", bus.inst_pc, head);
    check1("stall_req_c4", bus.imem_req, 1'b0);
    check1("stall_en_c4", bus.en, 1'b1);
    tick(1);
    check("stall_no_pops", 32'(obs_cnt - base), 32'd0);
    bus.dec_ready = 1'b1;
    tick(10);
    check1("stall_drained", obs_cnt > base + 5, 1'b1);
    drain("after_stall");

    // Redirect with two returns outstanding on a 3-cycle memory.
    lat = 3;
    k = 0;
    while ((bus.en || bus.imem_req) && k < 20) begin
      tick(1);
      k++;
    end
    check1("two_outstanding_reached", !bus.en && !bus.imem_req, 1'b1);
    do_redirect(32'h0000_0100, 32'h0000_0100);
    check("redir_addr", bus.imem_addr, 32'h0000_0100);
    check1("redir_en_low", bus.en, 1'b0);
    base = obs_cnt;
    wait_en("redir100");
    check("redir_first_pc", bus.inst_pc, 32'h0000_0100);
    tick(8);
    check1("redir100_progress", obs_cnt > base, 1'b1);
    drain("redir100");

    // Redirect coinciding with a pop and an arriving word.
    lat = 1;
    tick(8);
    check1("steady_en", bus.en, 1'b1);
    check1("steady_req", bus.imem_req, 1'b1);
    do_redirect(32'h0000_0300, 32'h0000_0300);
    check("redir300_addr", bus.imem_addr, 32'h0000_0300);
    check1("redir300_en_low", bus.en, 1'b0);
    base = obs_cnt;
    wait_en("redir300");
    check("redir300_first_pc", bus.inst_pc, 32'h0000_0300);
    tick(6);
    check1("redir300_progress", obs_cnt > base, 1'b1);
    drain("redir300");

    // Misaligned target halts fetch until an aligned redirect.
    do_redirect(32'h0000_0102, 32'h0000_0200);
    check1("mis_flag", bus.misaligned, 1'b1);
    check("mis_addr", bus.imem_addr, 32'h0000_0100);
    base = obs_cnt;
    for (int i = 0; i < 5; i++) begin
      check1("mis_req_low", bus.imem_req, 1'b0);
      check1("mis_en_low", bus.en, 1'b0);
      tick(1);
    end
    check("mis_no_pops", 32'(obs_cnt - base), 32'd0);
    do_redirect(32'h0000_0200, 32'h0000_0200);
    check1("mis_cleared", bus.misaligned, 1'b0);
    check("mis_new_addr", bus.imem_addr, 32'h0000_0200);
    check1("mis_req_back", bus.imem_req, 1'b1);
    wait_en("redir200");
    check("redir200_first_pc", bus.inst_pc, 32'h0000_0200);
    tick(6);
    drain("redir200");

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    check1("wrap_req", bus.imem_req, 1'b1);
    tick(1);
    check("wrap_addr_zero", bus.imem_addr, 32'h0000_0000);
    base = obs_cnt;
    tick(6);
    check1("wrap_progress", obs_cnt > base + 2, 1'b1);
    drain("wrap");

    // Stray response with nothing outstanding must be ignored.
    bus.imem_gnt = 1'b0;
    tick(5);
    check1("idle_en_low", bus.en, 1'b0);
    drain("pre_stray");
    head = exp_q[0];
    check("idle_addr", bus.imem_addr, head);
    stray_cnt++;
    tick(2);
    check1("stray_en_low", bus.en, 1'b0);
    check("stray_addr", bus.imem_addr, head);
    check1("stray_req", bus.imem_req, 1'b1);
    tick(2);
    check1("stray_en_low_late", bus.en, 1'b0);
    bus.imem_gnt = 1'b1;
    base = obs_cnt;
    wait_en("post_stray");
    tick(6);
    check1("post_stray_progress", obs_cnt > base + 2, 1'b1);
    drain("post_stray");

    // Asynchronous reset in the middle of traffic.
    rst_n = 1'b0;
    #1;
    check1("midrst_en", bus.en, 1'b0);
    check("midrst_addr", bus.imem_addr, ResetPc);
    check("midrst_code", bus.instruction_code, 32'h0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
